seq_reduce_unit: RTL and testbench

SEQ_REDUCE_UNIT -- requirements
Module: seq_reduce_unit

---
 rtl/seq_reduce_pkg.sv | 32 +++
 rtl/seq_reduce_alu.sv | 36 +++
 rtl/seq_reduce_unit.sv | 119 +++++++++++
 tb/tb_seq_reduce_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_reduce_pkg
// Description : Shared definitions for the sequential reduction unit: operation
//               encodings, FSM state encoding and a constant-foldable clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_reduce_pkg;

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_AVG = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0 so a single-operand unit adds no result bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_reduce_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_reduce_alu
// Description : Combinational fold step: combines the running accumulator with
//               a new unsigned operand according to the latched operation.
//               AVG folds like SUM; the final divide happens at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_reduce_alu
    import seq_reduce_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RW    = 5
) (
    input  logic [RW-1:0]    i_acc,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic [1:0]       i_mode,
    output logic [RW-1:0]    o_acc_next
);

    logic [RW-1:0] w_d_ext;

    assign w_d_ext = RW'(i_d_in);

    // Select the next accumulator value; ties in MIN/MAX keep the old value.
    always_comb begin
        o_acc_next = i_acc + w_d_ext;
        case (i_mode)
            MODE_MIN: o_acc_next = (w_d_ext < i_acc) ? w_d_ext : i_acc;
            MODE_MAX: o_acc_next = (w_d_ext > i_acc) ? w_d_ext : i_acc;
            default:  o_acc_next = i_acc + w_d_ext;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_reduce_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_reduce_unit
// Description : Collects COUNT unsigned operands (first flagged by start, the
//               rest by d_valid) and reduces them with SUM, MIN, MAX or AVG.
//               Result is registered and qualified by a one-cycle valid pulse.
//               Optional macro SEQ_REDUCE_AVG_EN turns mode 3 into a
//               truncating average (COUNT must then be a power of two);
//               without it mode 3 is plain SUM.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_reduce_unit
    import seq_reduce_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int COUNT = 2,
    localparam int RW    = WIDTH + clog2(COUNT)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_in,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic [RW-1:0]    result,
    output logic             valid
);

    localparam int         c_SHIFT = clog2(COUNT);
    localparam logic [4:0] c_LAST  = 5'(COUNT - 1);

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [RW-1:0] r_acc;
    logic [4:0]    r_n;
    logic [RW-1:0] r_result;
    logic          r_valid;
    logic          r_busy;

    logic [RW-1:0] w_first;
    logic [RW-1:0] w_acc_next;
    logic [RW-1:0] w_final;

    assign w_first = RW'(d_in);

    seq_reduce_alu #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_alu (
        .i_acc      (r_acc),
        .i_d_in     (d_in),
        .i_mode     (r_mode),
        .o_acc_next (w_acc_next)
    );

`ifdef SEQ_REDUCE_AVG_EN
    generate
        if ((COUNT & (COUNT - 1)) != 0) begin : g_avg_count_check
            $error("seq_reduce_unit: COUNT must be a power of two when AVG is enabled");
        end
    endgenerate

    // The average is the full-width sum shifted down, zero-filled from the top.
    assign w_final = (r_mode == MODE_AVG) ? (w_acc_next >> c_SHIFT) : w_acc_next;
`else
    assign w_final = w_acc_next;
`endif

    // Transaction FSM with operand counter and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_SUM;
            r_acc    <= '0;
            r_n      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                // Start wins in every state; an open transaction is dropped.
                r_mode <= mode;
                r_acc  <= w_first;
                r_n    <= 5'd1;
                if (COUNT == 1) begin
                    r_state  <= ST_DONE;
                    r_result <= w_first;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                end else begin
                    r_state <= ST_COLLECT;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == ST_COLLECT) begin
                if (d_valid) begin
                    r_acc <= w_acc_next;
                    r_n   <= r_n + 5'd1;
                    if (r_n == c_LAST) begin
                        r_state  <= ST_DONE;
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign busy   = r_busy;
    assign result = r_result;
    assign valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_seq_reduce_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_reduce_unit
// Description : Directed self-checking bench for seq_reduce_unit with three
//               instances (COUNT = 2, 4, 1) sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_reduce_unit;

    logic       clock = 1'b0;
    logic       rst;
    logic       start;
    logic       d_valid;
    logic [3:0] d_in;
    logic [1:0] mode;

    logic       busy2, valid2;
    logic [4:0] result2;
    logic       busy4, valid4;
    logic [5:0] result4;
    logic       busy1, valid1;
    logic [3:0] result1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    seq_reduce_unit #(.WIDTH(4), .COUNT(2)) u_dut2 (
        .clock(clock), .rst(rst), .start(start), .d_valid(d_valid),
        .d_in(d_in), .mode(mode), .busy(busy2), .result(result2), .valid(valid2)
    );

    seq_reduce_unit #(.WIDTH(4), .COUNT(4)) u_dut4 (
        .clock(clock), .rst(rst), .start(start), .d_valid(d_valid),
        .d_in(d_in), .mode(mode), .busy(busy4), .result(result4), .valid(valid4)
    );

    seq_reduce_unit #(.WIDTH(4), .COUNT(1)) u_dut1 (
        .clock(clock), .rst(rst), .start(start), .d_valid(d_valid),
        .d_in(d_in), .mode(mode), .busy(busy1), .result(result1), .valid(valid1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one input vector, clock it in, then settle past the edge.
    task automatic step(input logic s, input logic v, input logic [3:0] d, input logic [1:0] m);
        start   = s;
        d_valid = v;
        d_in    = d;
        mode    = m;
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; d_valid = 1'b0; d_in = '0; mode = '0;
        @(posedge clock); #1;
        step(1'b1, 1'b1, 4'd9, 2'd0);   // start/d_valid under reset are ignored
        check("rst_result2", result2, 0);
        check("rst_valid2", valid2, 0);
        check("rst_busy2", busy2, 0);
        check("rst_busy4", busy4, 0);
        check("rst_valid1", valid1, 0);
        rst = 1'b0;

        // SUM 9 + 12; first operand accepted on the first edge after reset
        step(1'b1, 1'b0, 4'd9, 2'd0);
        check("sum_busy_c1", busy2, 1);
        check("sum_valid_c1", valid2, 0);
        check("cnt1_result", result1, 9);
        check("cnt1_valid", valid1, 1);
        step(1'b0, 1'b1, 4'd12, 2'd0);
        check("sum_result", result2, 21);
        check("sum_valid", valid2, 1);
        check("sum_busy_done", busy2, 0);
        check("cnt1_valid_off", valid1, 0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        check("sum_valid_pulse", valid2, 0);
        check("sum_result_hold", result2, 21);

        // d_valid in IDLE is ignored
        step(1'b0, 1'b1, 4'd8, 2'd0);
        check("idle_dv_valid", valid2, 0);
        check("idle_dv_busy", busy2, 0);
        check("idle_dv_result", result2, 21);

        // MIN with a mid-transaction mode change that must be ignored
        step(1'b1, 1'b0, 4'd15, 2'd1);
        step(1'b0, 1'b1, 4'd3, 2'd2);
        check("min_result", result2, 3);
        check("min_valid", valid2, 1);
        // MAX, started in the DONE cycle
        step(1'b1, 1'b0, 4'd15, 2'd2);
        step(1'b0, 1'b1, 4'd3, 2'd0);
        check("max_result", result2, 15);
        // MIN tie
        step(1'b1, 1'b0, 4'd7, 2'd1);
        step(1'b0, 1'b1, 4'd7, 2'd1);
        check("min_tie_result", result2, 7);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        // Gaps and abort on the COUNT=4 instance
        step(1'b1, 1'b0, 4'd1, 2'd0);
        check("gap_busy_a", busy4, 1);
        step(1'b0, 1'b1, 4'd2, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'd0, 2'd0);
            check("gap_busy_idle", busy4, 1);
            check("gap_valid_idle", valid4, 0);
        end
        step(1'b1, 1'b0, 4'd5, 2'd0);
        check("abort_valid", valid4, 0);
        check("abort_busy", busy4, 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4'd5, 2'd0);
            check("abort_valid_mid", valid4, 0);
            check("abort_busy_mid", busy4, 1);
        end
        step(1'b0, 1'b1, 4'd5, 2'd0);
        check("abort_result", result4, 20);
        check("abort_valid_end", valid4, 1);
        check("abort_busy_end", busy4, 0);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        // Back-to-back on COUNT=2: valid pulses two cycles apart
        step(1'b1, 1'b0, 4'd9, 2'd0);
        step(1'b0, 1'b1, 4'd12, 2'd0);
        check("b2b_result_a", result2, 21);
        check("b2b_valid_a", valid2, 1);
        step(1'b1, 1'b0, 4'd3, 2'd1);
        check("b2b_valid_gap", valid2, 0);
        check("b2b_busy_gap", busy2, 1);
        step(1'b0, 1'b1, 4'd5, 2'd1);
        check("b2b_result_b", result2, 3);
        check("b2b_valid_b", valid2, 1);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        // Reset mid-transaction
        step(1'b1, 1'b0, 4'd6, 2'd0);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'd0, 2'd0);
        check("midrst_valid", valid2, 0);
        check("midrst_result", result2, 0);
        check("midrst_busy", busy2, 0);
        rst = 1'b0;
        step(1'b1, 1'b0, 4'd4, 2'd0);
        check("postrst_busy", busy2, 1);
        step(1'b0, 1'b1, 4'd4, 2'd0);
        check("postrst_result", result2, 8);
        check("postrst_valid", valid2, 1);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        // Mode 3 on COUNT=4: average when enabled, otherwise plain sum
        step(1'b1, 1'b0, 4'd15, 2'd3);
        step(1'b0, 1'b1, 4'd15, 2'd3);
        step(1'b0, 1'b1, 4'd15, 2'd3);
        step(1'b0, 1'b1, 4'd14, 2'd3);
        check("mode3_valid", valid4, 1);
`ifdef SEQ_REDUCE_AVG_EN
        check("mode3_result", result4, 14);
`else
        check("mode3_result", result4, 59);
`endif
        // SUM at full scale on COUNT=4 must not overflow
        step(1'b1, 1'b0, 4'd15, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd15, 2'd0);
        check("sum_max_result", result4, 60);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
